// File: rtl/logic_result_stage.sv
// Output stage for the bitwise gate array. It picks one gate result per transaction,
// computes zero/neg flags and holds results in a 2-entry queue with valid/ready on both sides.
module logic_result_stage #(
  parameter int BITS     = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [BITS-1:0]     and_i,
  input  logic [BITS-1:0]     or_i,
  input  logic [BITS-1:0]     xor_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [BITS-1:0]     result_o,
  output logic                zero_o,
  output logic                neg_o,
  output logic [CNT_BITS-1:0] acc_cnt_o
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef struct packed {
    logic [BITS-1:0] result;
    logic            zero;
    logic            neg;
  } entry_t;

  entry_t              mem_q [2];
  entry_t              entry_d;
  entry_t              head;
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] acc_cnt_q;
  logic [BITS-1:0]     sel;
  logic                push, pop;

  // Handshake flags depend on registered occupancy only, so no input-to-output combinational path.
  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    sel = '0;
    unique case (op_e'(op_i))
      OP_AND:  sel = and_i;
      OP_OR:   sel = or_i;
      OP_XOR:  sel = xor_i;
      OP_NOR:  sel = ~or_i;
      default: sel = '0;
    endcase
  end

  always_comb begin
    entry_d.result = sel;
    entry_d.zero   = (sel == '0);
    entry_d.neg    = sel[BITS-1];
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q  <= ~wr_ptr_q;
        acc_cnt_q <= acc_cnt_q + CNT_BITS'(1);
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: storage is not reset; an entry is only visible while count_q covers it, and outputs are masked otherwise.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign result_o  = out_valid_o ? head.result : '0;
  assign zero_o    = out_valid_o & head.zero;
  assign neg_o     = out_valid_o & head.neg;
  assign acc_cnt_o = acc_cnt_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Scoreboard bench for logic_result_stage: recorder pushes expected entries on accepted
// transactions, monitor pops and compares on every output handshake.
module tb_logic_result_stage;

  localparam int BITS     = 4;
  localparam int CNT_BITS = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready, out_valid, out_ready;
  logic [1:0]          op;
  logic [BITS-1:0]     and_v, or_v, xor_v, result;
  logic                zero, neg;
  logic [CNT_BITS-1:0] acc_cnt;

  typedef struct packed {
    logic [BITS-1:0] result;
    logic            zero;
    logic            neg;
  } exp_t;

  exp_t sb[$];
  int   acc_model;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic_result_stage #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .and_i(and_v), .or_i(or_v), .xor_i(xor_v),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero), .neg_o(neg),
    .acc_cnt_o(acc_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result is the op-selected gate value (NOR = inverted OR), flags derived arithmetically.
  function automatic exp_t model(input logic [1:0] o, input logic [BITS-1:0] a,
                                 input logic [BITS-1:0] b, input logic [BITS-1:0] x);
    exp_t e;
    int   v;
    case (o)
      2'd0:    v = int'(a);
      2'd1:    v = int'(b);
      2'd2:    v = int'(x);
      default: v = (2**BITS - 1) - int'(b);
    endcase
    e.result = BITS'(v);
    e.zero   = (v == 0);
    e.neg    = (v >= 2**(BITS-1));
    return e;
  endfunction

  // Recorder: enqueue the expected entry just after the monitor has seen pre-edge occupancy.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e = model(op, and_v, or_v, xor_v);
      #1;
      sb.push_back(e);
      acc_model++;
    end
  end

  // Monitor: flags against model occupancy, payload against scoreboard head on every pop.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      check("acc_cnt", 32'(acc_cnt), 32'(acc_model % (2**CNT_BITS)));
      if (!out_valid) begin
        check("idle_out", {28'd0, result, zero, neg}, 32'd0);
      end else if (sb.size() != 0) begin
        check("head", 32'({result, zero, neg}), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic v, input logic [1:0] o, input logic [BITS-1:0] a,
                     input logic [BITS-1:0] b, input logic [BITS-1:0] x, input logic r);
    in_valid = v; op = o; and_v = a; or_v = b; xor_v = x; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;          // mid-cycle, away from any edge
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_acc", 32'(acc_cnt), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    sb.delete();
    acc_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0;
    and_v = '0; or_v = '0; xor_v = '0; acc_model = 0;
    @(posedge clk); #1;
    do_reset();

    // Single OR push, popped on the following edge
    cyc(1'b1, 2'b01, 4'b0000, 4'b1010, 4'b0000, 1'b1);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_result", {28'd0, result}, 32'b1010);
    check("t2_flags", {30'd0, zero, neg}, 32'b01);
    cyc(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("t2_popped", {27'd0, out_valid, result}, 32'd0);

    // Op coverage, in order
    cyc(1'b1, 2'b00, 4'b0000, 4'b0110, 4'b0101, 1'b1);
    check("t3_and", {27'd0, result, zero}, {27'd0, 4'b0000, 1'b1});
    cyc(1'b1, 2'b10, 4'b0000, 4'b0110, 4'b0101, 1'b1);
    check("t3_xor", {27'd0, result, neg}, {27'd0, 4'b0101, 1'b0});
    cyc(1'b1, 2'b11, 4'b0000, 4'b0110, 4'b0101, 1'b1);
    check("t3_nor", {27'd0, result, neg}, {27'd0, 4'b1001, 1'b1});
    drain();

    // Backpressure: three pushes with downstream stalled
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 4'b0, 4'b0, 4'(i + 1), 1'b0);
    check("t4_stall", 32'(in_ready), 32'd0);
    check("t4_acc", 32'(acc_cnt), 32'd2);
    check("t4_head", 32'(result), 32'd1);
    cyc(1'b1, 2'b10, 4'b0, 4'b0, 4'd3, 1'b1);
    check("t4_freed", 32'(in_ready), 32'd1);
    check("t4_next", 32'(result), 32'd2);
    cyc(1'b1, 2'b10, 4'b0, 4'b0, 4'd3, 1'b0);
    check("t4_acc3", 32'(acc_cnt), 32'd3);
    drain();

    // Streaming at count=1
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 2'b10, 4'b0, 4'b0, 4'(i), 1'b1);
      check("t5_stream", 32'(result), 32'(i));
    end
    check("t5_acc", 32'(acc_cnt), 32'd10);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          1'($urandom_range(0, 3) != 0));
    drain();

    // Counter wrap, then reset with two entries buffered
    do_reset();
    for (int i = 0; i < 257; i++) cyc(1'b1, 2'b01, 4'b0, 4'(i), 4'b0, 1'b1);
    check("t6_wrap", 32'(acc_cnt), 32'd1);
    drain();
    cyc(1'b1, 2'b01, 4'b0, 4'd7, 4'b0, 1'b0);
    cyc(1'b1, 2'b01, 4'b0, 4'd8, 4'b0, 1'b0);
    check("t6_full", 32'(in_ready), 32'd0);
    do_reset();
    cyc(1'b0, 2'b00, 4'b0, 4'b0, 4'b0, 1'b0);
    check("t6_empty", {27'd0, out_valid, result}, 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_result_stage.md
Name: logic_result_stage

Overview:
- Registered output stage directly downstream of the bitwise gate array (AND/OR/XOR gates, BITS wide).
- Selects one gate result per transaction, computes zero/negative flags and buffers the result in a 2-entry skid queue.
- Uses a valid/ready handshake on both sides, so the combinational gate outputs feed a pipelined datapath with no combinational path from input to output.

Parameters:
- BITS, 4, width of the gate buses and of result_o.
- CNT_BITS, 8, width of the accepted-transaction counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  upstream presents a valid transaction.
- in_ready_o  out  1  stage can accept this cycle.
- op_i  in  2  select: 00 AND, 01 OR, 10 XOR, 11 NOR (bitwise NOT of or_i).
- and_i  in  BITS  AND gate output (bus_o of the and gate).
- or_i  in  BITS  OR gate output (bus_o of the or gate).
- xor_i  in  BITS  XOR gate output.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head.
- result_o  out  BITS  head result.
- zero_o  out  1  head result == 0.
- neg_o  out  1  head result MSB.
- acc_cnt_o  out  CNT_BITS  number of accepted transactions, wraps modulo 2^CNT_BITS.

Behaviour:
- Reset, asynchronous, rst_i=1:
  - Queue empty (count=0); read and write pointers 0; acc_cnt_o=0.
  - out_valid_o=0; result_o=0, zero_o=0, neg_o=0.
  - in_ready_o=1 while in reset and after release.
  - Reset mid-transaction discards all buffered entries; no entry survives.
- Storage:
  - 2 entries, each {result[BITS-1:0], zero, neg}.
  - Entries are computed at push time from the op_i-selected input: zero = (sel==0), neg = sel[BITS-1].
- Handshakes:
  - Push when in_valid_i & in_ready_o.
  - Pop when out_valid_o & out_ready_i.
  - in_ready_o = (count != 2). It is a function of registered state only and must not depend on out_ready_i.
  - out_valid_o = (count != 0), registered-state only.
- Latency:
  - A transaction pushed at edge N appears at the head with out_valid_o=1 after edge N if the queue was empty.
  - Minimum latency is 1 cycle; there is no same-cycle pass-through.
- Count transitions:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together (possible only at count=1): count stays 1; the head advances to the new entry and both pointers advance.
  - count=2: in_ready_o=0 and upstream stalls; a pop frees a slot, and in_ready_o=1 in the following cycle.
  - count=0: no pop possible; out_ready_i is ignored.
- Pointers: 1-bit, toggle on their respective events, and wrap 1→0.
- Output values:
  - When out_valid_o=0, result_o, zero_o and neg_o are forced to 0.
  - When out_valid_o=1, they show the head entry and hold stable until popped, even if op_i or the gate inputs change.
- Counter: acc_cnt_o increments by 1 per push and wraps from 2^CNT_BITS-1 to 0.
- Input sampling: inputs are ignored when in_valid_i=0 or in_ready_o=0. op_i is sampled only on push.

Test Plan:
1. Reset with rst_i pulsed asynchronously mid-cycle → immediately out_valid_o=0, result_o=0, acc_cnt_o=0, in_ready_o=1.
2. BITS=4; push op=01 with or_i=4'b1010, out_ready_i=1 → next cycle out_valid_o=1, result_o=4'b1010, zero_o=0, neg_o=1. Popped that edge, then out_valid_o=0, result_o=0.
3. Op coverage, using and_i=4'b0000, or_i=4'b0110, xor_i=4'b0101:
   - Push op 00 → result_o=0000, zero_o=1.
   - Push op 10 → result_o=0101, neg_o=0.
   - Push op 11 → result_o=1001, neg_o=1.
   - Results must arrive in order.
4. Backpressure: out_ready_i=0, three consecutive valid pushes → only two accepted; in_ready_o=0 from the cycle after the second push; acc_cnt_o=2. Raise out_ready_i for one cycle → the first result pops, in_ready_o=1 next cycle, and the third push is then accepted.
5. Simultaneous push/pop at count=1 for 10 cycles with streaming data 0..9 → count stays 1, outputs are 0..9 in order at 1-cycle latency, and acc_cnt_o=10.
6. Wrap: CNT_BITS=8, 257 pushes → acc_cnt_o=1. Asserting rst_i with 2 entries buffered → out_valid_o=0 at once, and the queue is empty after release.
